// File: rtl/dmem_lsu_pkg.sv
// dmem_pkg: shared encodings for the data-memory load/store unit.
//   - SZ_*     : access-size encodings carried on req_size
//   - state_e  : FSM states of the request/response sequencer
//   - misaligned(): alignment check on the low address bits
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Only the two lane bits matter for alignment; callers pass addr[1:0].
  function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] size);
    case (size)
      SZ_HALF: return addr[0];
      SZ_WORD: return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bus between the core memory stage (master)
// and the data-memory block (slave).
//   req_valid/req_ready : request handshake
//   req_write, req_addr, req_size, req_unsigned, req_wdata : request fields
//   rsp_valid, rsp_rdata, rsp_err : one-cycle response
interface dmem_lsu_if #(parameter int ADDR_W = 10);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lsu_ram.sv
// dmem_ram: 32-bit word RAM, 2^(ADDR_W-2) words, per-byte write enable,
// registered read. No reset on storage or read register.
//   clk   : clock
//   en    : access enable (read register and any enabled lanes update)
//   we    : byte-lane write enables, lane 0 = bits [7:0]
//   addr  : word index
//   wdata : lane-replicated write data
//   rdata : registered read data (old contents on a same-cycle write)
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**(ADDR_W-2)];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with a load/store front end.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem_lsu_if slave (valid/ready request, one-cycle response)
// One access in flight at a time. The RAM is touched on the edge that enters
// RESP; the load lane is extracted and extended combinationally during RESP.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       hold_q, hold_d;

  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept, enter_resp;
  logic              a_write, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic [31:0]       a_wdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata, ram_rdata, load_data;

  function automatic logic [3:0] lane_be(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow data across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lane_steer(input logic [31:0] d, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: return {{24{b[7] & ~uns}}, b};
      SZ_HALF: return {{16{h[15] & ~uns}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    accept = (state_q == ST_IDLE) && bus.req_valid;

    // With LATENCY=1 the RAM edge is the accept edge, so the live request is used.
    if (state_q == ST_IDLE) begin
      a_write = bus.req_write;
      a_addr  = bus.req_addr;
      a_size  = bus.req_size;
      a_wdata = bus.req_wdata;
    end else begin
      a_write = write_q;
      a_addr  = addr_q;
      a_size  = size_q;
      a_wdata = wdata_q;
    end
    a_err = misaligned(a_addr[1:0], a_size) || (a_size == SZ_RSVD);

    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    if (accept) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
      wdata_d = bus.req_wdata;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    enter_resp  = (state_d == ST_RESP) && (state_q != ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = enter_resp;
    rsp_err_d   = enter_resp ? a_err : rsp_err_q;

    // Reset on the RESP-entry edge must block the write.
    ram_en    = enter_resp && !a_err && rst_n;
    ram_we    = a_write ? lane_be(a_addr[1:0], a_size) : 4'b0000;
    ram_wdata = lane_steer(a_wdata, a_size);

    load_data = (write_q || rsp_err_q) ? 32'd0
              : load_extend(ram_rdata, addr_q[1:0], size_q, uns_q);
    hold_d    = (state_q == ST_RESP) ? load_data : hold_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      hold_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      hold_q      <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (a_addr[ADDR_W-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = (state_q == ST_RESP) ? load_data : hold_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu. Two instances share the clock:
// u_dut1 with LATENCY=1 and u_dut4 with LATENCY=4, each on its own reset.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst4_n;

  dmem_lsu_if #(.ADDR_W(10)) bus1 ();
  dmem_lsu_if #(.ADDR_W(10)) bus4 ();

  dmem_lsu #(.ADDR_W(10), .LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));
  dmem_lsu #(.ADDR_W(10), .LATENCY(4)) u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic [9:0] a,
                       input logic [1:0] s, input logic u, input logic [31:0] d);
    if (sel == 4) begin
      bus4.req_valid = v; bus4.req_write = w; bus4.req_addr = a;
      bus4.req_size = s;  bus4.req_unsigned = u; bus4.req_wdata = d;
    end else begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a;
      bus1.req_size = s;  bus1.req_unsigned = u; bus1.req_wdata = d;
    end
  endtask

  function automatic logic get_vld(input int sel);
    return (sel == 4) ? bus4.rsp_valid : bus1.rsp_valid;
  endfunction
  function automatic logic get_rdy(input int sel);
    return (sel == 4) ? bus4.req_ready : bus1.req_ready;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 4) ? bus4.rsp_err : bus1.rsp_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 4) ? bus4.rsp_rdata : bus1.rsp_rdata;
  endfunction

  // One access: latency measured in cycles after the accept edge must equal
  // the instance's LATENCY (sel is 1 or 4), then response and pulse checks.
  task automatic lsu_req(input int sel, input string tag, input logic w, input logic [9:0] a,
                         input logic [1:0] s, input logic u, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    bit seen;
    @(negedge clk);
    drive(sel, 1'b1, w, a, s, u, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'd0);
    n = 1;
    seen = 1'b0;
    while (n <= 20) begin
      if (get_vld(sel)) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, seen ? 32'(n) : 32'd99, 32'(sel));
    check({tag, "_rdata"}, get_rdata(sel), exp_rdata);
    check({tag, "_err"}, {31'd0, get_err(sel)}, {31'd0, exp_err});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, get_vld(sel)}, 32'd0);
    check({tag, "_hold"}, get_rdata(sel), exp_rdata);
  endtask

  int lowcnt, vpos, extra;

  initial begin
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    drive(1, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'd0);
    drive(4, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus1.req_ready}, 32'd1);
    check("rst_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("rst_err",   {31'd0, bus1.rsp_err},   32'd0);
    check("rst_rdata", bus1.rsp_rdata,          32'd0);
    check("rst4_ready", {31'd0, bus4.req_ready}, 32'd1);
    @(negedge clk);
    rst1_n = 1'b1;
    rst4_n = 1'b1;

    // LATENCY=1 instance
    lsu_req(1, "sw10",  1'b1, 10'h010, SZ_WORD, 1'b0, 32'hDEADBEEF, 32'd0,         1'b0);
    lsu_req(1, "lw10",  1'b0, 10'h010, SZ_WORD, 1'b0, 32'd0,        32'hDEADBEEF,  1'b0);
    lsu_req(1, "sw20",  1'b1, 10'h020, SZ_WORD, 1'b0, 32'h11223344, 32'd0,         1'b0);
    lsu_req(1, "sb22",  1'b1, 10'h022, SZ_BYTE, 1'b0, 32'h000000AA, 32'd0,         1'b0);
    lsu_req(1, "lw20",  1'b0, 10'h020, SZ_WORD, 1'b1, 32'd0,        32'h11AA3344,  1'b0);
    lsu_req(1, "lb22",  1'b0, 10'h022, SZ_BYTE, 1'b0, 32'd0,        32'hFFFFFFAA,  1'b0);
    lsu_req(1, "lbu22", 1'b0, 10'h022, SZ_BYTE, 1'b1, 32'd0,        32'h000000AA,  1'b0);
    lsu_req(1, "lb21",  1'b0, 10'h021, SZ_BYTE, 1'b0, 32'd0,        32'h00000033,  1'b0);
    lsu_req(1, "sh32",  1'b1, 10'h032, SZ_HALF, 1'b0, 32'h00008001, 32'd0,         1'b0);
    lsu_req(1, "lh32",  1'b0, 10'h032, SZ_HALF, 1'b0, 32'd0,        32'hFFFF8001,  1'b0);
    lsu_req(1, "lhu32", 1'b0, 10'h032, SZ_HALF, 1'b1, 32'd0,        32'h00008001,  1'b0);
    lsu_req(1, "sw40",  1'b1, 10'h040, SZ_WORD, 1'b0, 32'hCAFEF00D, 32'd0,         1'b0);
    lsu_req(1, "sw41",  1'b1, 10'h041, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'd0,         1'b1);
    lsu_req(1, "lh43",  1'b0, 10'h043, SZ_HALF, 1'b0, 32'd0,        32'd0,         1'b1);
    lsu_req(1, "rsv40", 1'b1, 10'h040, SZ_RSVD, 1'b0, 32'h01010101, 32'd0,         1'b1);
    lsu_req(1, "lw40",  1'b0, 10'h040, SZ_WORD, 1'b0, 32'd0,        32'hCAFEF00D,  1'b0);

    // LATENCY=4 instance
    lsu_req(4, "sw50",  1'b1, 10'h050, SZ_WORD, 1'b0, 32'h12345678, 32'd0,         1'b0);
    lsu_req(4, "lw50",  1'b0, 10'h050, SZ_WORD, 1'b0, 32'd0,        32'h12345678,  1'b0);

    // Request held high across the whole transaction is taken only once.
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 10'h060, SZ_WORD, 1'b0, 32'hA5A5A5A5);
    @(posedge clk); #1;
    lowcnt = 0;
    vpos = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!bus4.req_ready) lowcnt++;
      if (bus4.rsp_valid && vpos == 0) vpos = i;
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    check("hold_ready_low", 32'(lowcnt), 32'd4);
    check("hold_vld_pos", 32'(vpos), 32'd4);
    drive(4, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'd0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus4.rsp_valid) extra++;
    end
    check("hold_single", 32'(extra), 32'd0);
    lsu_req(4, "lw60",  1'b0, 10'h060, SZ_WORD, 1'b0, 32'd0,        32'hA5A5A5A5,  1'b0);

    // Reset during WAIT cancels the store.
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 10'h050, SZ_WORD, 1'b0, 32'h00000055);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst4_n = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b1;
    @(posedge clk); #1;
    check("rstw_ready", {31'd0, bus4.req_ready}, 32'd1);
    check("rstw_rdata", bus4.rsp_rdata, 32'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus4.rsp_valid) extra++;
      @(posedge clk); #1;
    end
    check("rstw_novalid", 32'(extra), 32'd0);
    lsu_req(4, "lw50a", 1'b0, 10'h050, SZ_WORD, 1'b0, 32'd0,        32'h12345678,  1'b0);

    // Reset on the edge that would enter RESP also blocks the store.
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 10'h050, SZ_WORD, 1'b0, 32'h00000066);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4_n = 1'b0;
    @(posedge clk); #1;
    check("rstr_novalid", {31'd0, bus4.rsp_valid}, 32'd0);
    rst4_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus4.rsp_valid) extra++;
    end
    check("rstr_novalid2", 32'(extra), 32'd0);
    lsu_req(4, "lw50b", 1'b0, 10'h050, SZ_WORD, 1'b0, 32'd0,        32'h12345678,  1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: never let the run hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
